fab_cfg_loader: RTL and testbench

FAB_CFG_LOADER -- requirements
Module: fab_cfg_loader

---
 rtl/fab_cfg_pkg.sv | 30 +++
 rtl/fab_cfg_word_pack.sv | 48 ++++
 rtl/fab_cfg_loader.sv | 165 ++++++++++++++++
 tb/tb_fab_cfg_loader.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fab_cfg_pkg.sv
// fab_cfg_pkg: shared types and constants for the fabric configuration loader.
package fab_cfg_pkg;

    // Byte, word and payload-count widths used across the loader.
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned COUNT_W = 32;

    // Bytes per configuration word (and per length field).
    localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;

    // Default start-of-bitstream marker.
    localparam logic [WORD_W-1:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

    // Loader control states.
    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_LEN   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_e;

    // States in which the loader takes bytes from the upstream source.
    function automatic logic accepts_bytes(input state_e s);
        return (s == ST_HUNT) || (s == ST_LEN) || (s == ST_LOAD);
    endfunction

endpackage

// File: rtl/fab_cfg_word_pack.sv
// fab_cfg_word_pack: assembles four bytes MSB-first into one 32-bit word.
// The first three bytes are held; the fourth is taken straight from the
// input so the complete word is available on the accepting edge.
module fab_cfg_word_pack
    import fab_cfg_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,       // drop any partial word, index to 0
    input  logic              push_i,      // byte_i is accepted this cycle
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,      // valid when complete_o is high
    output logic              complete_o   // this push delivers the 4th byte
);

    localparam int unsigned ACC_W = WORD_W - BYTE_W;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]       idx_q, idx_d;

    // Next-state for the byte accumulator and byte index.
    always_comb begin
        acc_d = acc_q;
        idx_d = idx_q;
        if (clr_i) begin
            acc_d = '0;
            idx_d = '0;
        end else if (push_i) begin
            acc_d = {acc_q[ACC_W-BYTE_W-1:0], byte_i};
            idx_d = idx_q + 2'd1;
        end
    end

    // Accumulator and index registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            idx_q <= '0;
        end else begin
            acc_q <= acc_d;
            idx_q <= idx_d;
        end
    end

    assign word_o     = {acc_q, byte_i};
    assign complete_o = push_i && (idx_q == 2'd3);

endmodule

// File: rtl/fab_cfg_loader.sv
// fab_cfg_loader: hunts a byte stream for the sync word, reads a 32-bit
// payload word count, then writes each payload word to the fabric config
// port with a one-cycle strobe followed by an enforced idle gap.
module fab_cfg_loader
    import fab_cfg_pkg::*;
#(
    parameter logic [WORD_W-1:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
    parameter int unsigned       STROBE_GAP = 2,
    parameter int unsigned       MAX_WORDS  = 65535
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic [BYTE_W-1:0] byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              rearm,
    output logic [WORD_W-1:0] SelfWriteData,
    output logic              SelfWriteStrobe,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Gap counter wide enough to reach STROBE_GAP; the strobe cycle is
    // the first GAP cycle, so GAP lasts STROBE_GAP + 1 cycles in total.
    localparam int unsigned GAP_W = (STROBE_GAP < 2) ? 1 : $clog2(STROBE_GAP + 1);

    // Only the three most recent bytes are stored; the fourth is the
    // incoming byte, compared directly on the accepting edge.
    localparam int unsigned WIN_W = WORD_W - BYTE_W;

    state_e             state_q, state_d;
    logic [WIN_W-1:0]   window_q, window_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic               strobe_q, strobe_d;

    logic               accept;
    logic               rearm_go;
    logic [WORD_W-1:0]  window_next;
    logic               sync_hit;
    logic               pack_push;
    logic [WORD_W-1:0]  pack_word;
    logic               pack_complete;
    logic               len_done;
    logic               word_done;
    logic               gap_last;
    logic               len_too_big;

    assign accept      = byte_valid && byte_ready;
    assign rearm_go    = rearm && ((state_q == ST_DONE) || (state_q == ST_ERROR));
    assign window_next = {window_q, byte_data};
    assign sync_hit    = (state_q == ST_HUNT) && accept && (window_next == SYNC_WORD);
    assign pack_push   = accept && ((state_q == ST_LEN) || (state_q == ST_LOAD));
    assign len_done    = pack_complete && (state_q == ST_LEN);
    assign word_done   = pack_complete && (state_q == ST_LOAD);
    assign gap_last    = (gap_q == GAP_W'(STROBE_GAP));
    assign len_too_big = (pack_word > COUNT_W'(MAX_WORDS));

    // Shared byte packer for both the length field and payload words.
    fab_cfg_word_pack u_pack (
        .clk_i      (CLK),
        .rst_ni     (resetn),
        .clr_i      (rearm_go),
        .push_i     (pack_push),
        .byte_i     (byte_data),
        .word_o     (pack_word),
        .complete_o (pack_complete)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT: begin
                if (sync_hit) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (len_done) begin
                    if (pack_word == '0)  state_d = ST_DONE;
                    else if (len_too_big) state_d = ST_ERROR;
                    else                  state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (word_done) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_last) state_d = (count_q == '0) ? ST_DONE : ST_LOAD;
            end
            ST_DONE, ST_ERROR: begin
                if (rearm) state_d = ST_HUNT;
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        byte_ready = accepts_bytes(state_q);
        busy       = (state_q == ST_LEN) || (state_q == ST_LOAD);
        done       = (state_q == ST_DONE);
        error      = (state_q == ST_ERROR);
    end

    // Datapath next-state: sync window, word count, gap timer, write port.
    always_comb begin
        window_d = window_q;
        count_d  = count_q;
        gap_d    = gap_q;
        data_d   = data_q;
        strobe_d = 1'b0;

        if (rearm_go) begin
            window_d = '0;
        end else if ((state_q == ST_HUNT) && accept) begin
            window_d = window_next[WIN_W-1:0];
        end

        if (len_done) begin
            count_d = pack_word;
        end else if (word_done) begin
            count_d = count_q - 1'b1;
        end

        if (word_done) begin
            gap_d    = '0;
            data_d   = pack_word;
            strobe_d = 1'b1;
        end else if ((state_q == ST_GAP) && !gap_last) begin
            gap_d = gap_q + 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            window_q <= '0;
            count_q  <= '0;
            gap_q    <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            window_q <= window_d;
            count_q  <= count_d;
            gap_q    <= gap_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

    assign SelfWriteData   = data_q;
    assign SelfWriteStrobe = strobe_q;

endmodule

// File: tb/tb_fab_cfg_loader.sv
// tb_fab_cfg_loader: randomized and directed stimulus against a
// stream-level reference model of the configuration loader.
`timescale 1ns/1ps
module tb_fab_cfg_loader;

    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
    localparam int          SG   = 2;
    localparam int unsigned MAXW = 65535;

    logic        CLK = 1'b0;
    logic        resetn = 1'b1;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_valid = 1'b0;
    logic        rearm = 1'b0;
    logic        byte_ready;
    logic [31:0] SelfWriteData;
    logic        SelfWriteStrobe;
    logic        busy, done, error;

    always #5 CLK = ~CLK;

    fab_cfg_loader #(.SYNC_WORD(SYNC), .STROBE_GAP(SG), .MAX_WORDS(MAXW)) u_dut (
        .CLK             (CLK),
        .resetn          (resetn),
        .byte_data       (byte_data),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .rearm           (rearm),
        .SelfWriteData   (SelfWriteData),
        .SelfWriteStrobe (SelfWriteStrobe),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    // Second instance: zero gap, byte_valid tied high.
    logic        rst0_n = 1'b1;
    logic [7:0]  d0;
    logic        rdy0, stb0, busy0, done0, err0;
    logic [31:0] dat0;
    logic [7:0]  s0 [0:23];
    int          idx0 = 0;
    bit          gap0_finished = 0;

    assign d0 = (idx0 < 24) ? s0[idx0] : 8'h00;

    fab_cfg_loader #(.SYNC_WORD(SYNC), .STROBE_GAP(0), .MAX_WORDS(MAXW)) u_dut_gap0 (
        .CLK             (CLK),
        .resetn          (rst0_n),
        .byte_data       (d0),
        .byte_valid      (1'b1),
        .byte_ready      (rdy0),
        .rearm           (1'b0),
        .SelfWriteData   (dat0),
        .SelfWriteStrobe (stb0),
        .busy            (busy0),
        .done            (done0),
        .error           (err0)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // ---------------- reference model (stream level) ----------------
    logic [31:0] m_win;
    bit          m_synced, m_have_len, m_strobe;
    logic [31:0] m_left, m_last;
    int          m_stall;   // remaining cycles with no byte acceptance
    int          m_end;     // 0 running, 1 done, 2 error
    logic [7:0]  m_q[$];

    task automatic model_reset();
        m_win = '0; m_synced = 0; m_have_len = 0; m_strobe = 0;
        m_left = '0; m_last = '0; m_stall = 0; m_end = 0;
        m_q.delete();
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic ra);
        logic [31:0] w;
        m_strobe = 0;
        if (m_end != 0) begin
            if (ra) begin
                m_end = 0; m_synced = 0; m_win = '0; m_q.delete();
            end
        end else if (m_stall > 0) begin
            m_stall--;
            if (m_stall == 0 && m_left == 0) m_end = 1;
        end else if (v) begin
            if (!m_synced) begin
                m_win = {m_win[23:0], d};
                if (m_win == SYNC) begin
                    m_synced = 1; m_have_len = 0; m_q.delete();
                end
            end else begin
                m_q.push_back(d);
                if (m_q.size() == 4) begin
                    w = {m_q[0], m_q[1], m_q[2], m_q[3]};
                    m_q.delete();
                    if (!m_have_len) begin
                        if (w == 0)         m_end = 1;
                        else if (w > MAXW)  m_end = 2;
                        else begin m_left = w; m_have_len = 1; end
                    end else begin
                        m_left--; m_last = w; m_strobe = 1; m_stall = SG + 1;
                    end
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge resetn);
            if (!resetn) model_reset();
            else model_step(byte_valid, byte_data, rearm);
        end
    end

    // ---------------- per-cycle compare and strobe log ----------------
    logic [31:0] dut_log[$];
    int          low_run = 0;
    bit          in_run = 0;
    int          last_gap_run = 0;

    initial forever begin
        @(negedge CLK);
        if (!resetn) begin
            check("rst_strobe", 32'(SelfWriteStrobe), 32'(0));
            check("rst_data",   SelfWriteData, 32'h0);
            check("rst_busy",   32'(busy),  32'(0));
            check("rst_done",   32'(done),  32'(0));
            check("rst_error",  32'(error), 32'(0));
        end else begin
            check("byte_ready", 32'(byte_ready), 32'(m_end == 0 && m_stall == 0));
            check("busy",       32'(busy),  32'(m_synced && m_end == 0 && m_stall == 0));
            check("done",       32'(done),  32'(m_end == 1));
            check("error",      32'(error), 32'(m_end == 2));
            check("strobe",     32'(SelfWriteStrobe), 32'(m_strobe));
            check("data",       SelfWriteData, m_last);
            if (SelfWriteStrobe === 1'b1) dut_log.push_back(SelfWriteData);
            if (SelfWriteStrobe === 1'b1) begin in_run = 1; low_run = 0; end
            if (in_run) begin
                if (!byte_ready) low_run++;
                else begin last_gap_run = low_run; in_run = 0; end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] stream[$];

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic add_word(input logic [31:0] w);
        stream.push_back(w[31:24]); stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);  stream.push_back(w[7:0]);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit jit, input bit noise);
        bit acc = 0;
        if (jit) begin
            while ($urandom_range(0, 2) == 0) begin
                byte_valid = 0;
                byte_data  = 8'($urandom);
                rearm      = noise && ($urandom_range(0, 4) == 0);
                tick();
                rearm = 0;
            end
        end
        byte_valid = 1;
        byte_data  = d;
        for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge CLK);
            acc = byte_ready;
            tick();
        end
        if (!acc) timeout_fail("send_byte");
        byte_valid = 0;
    endtask

    task automatic send_stream(input bit jit, input bit noise);
        foreach (stream[i]) send_byte(stream[i], jit, noise);
        stream.delete();
    endtask

    task automatic wait_end(input string tag);
        bit seen = 0;
        for (int t = 0; t < 80 && !seen; t++) begin
            @(negedge CLK);
            seen = done | error;
        end
        if (!seen) timeout_fail(tag);
        tick();
    endtask

    task automatic do_rearm();
        rearm = 1; tick(); rearm = 0;
    endtask

    // ---------------- main sequence ----------------
    int          base;
    logic [31:0] words[3];
    logic [31:0] n;

    initial begin
        #1 resetn = 0;
        repeat (3) tick();
        check("rst_data_lit", SelfWriteData, 32'h0);
        resetn = 1;
        @(negedge CLK);
        check("post_rst_ready", 32'(byte_ready), 32'(1));
        check("post_rst_busy",  32'(busy), 32'(0));
        tick();

        // Two-word load with a leading junk byte.
        base = dut_log.size();
        last_gap_run = 0;
        stream.push_back(8'h00);
        add_word(SYNC); add_word(32'd2);
        add_word(32'h11223344); add_word(32'h55667788);
        send_stream(0, 0);
        wait_end("t1_end");
        check("t1_done",     32'(done), 32'(1));
        check("t1_nstrobes", 32'(dut_log.size() - base), 32'(2));
        if (dut_log.size() >= base + 2) begin
            check("t1_word0", dut_log[base],     32'h11223344);
            check("t1_word1", dut_log[base + 1], 32'h55667788);
        end
        check("t1_gap_ge2", 32'((last_gap_run - 1) >= 2), 32'(1));
        check("t1_model_last", m_last, 32'h55667788);
        do_rearm();

        // Overlapping partial sync, zero-length payload.
        base = dut_log.size();
        stream.push_back(8'hFA);
        add_word(SYNC); add_word(32'd0);
        send_stream(0, 0);
        wait_end("t2_end");
        check("t2_done",     32'(done), 32'(1));
        check("t2_nstrobes", 32'(dut_log.size() - base), 32'(0));
        do_rearm();

        // Count one above the limit.
        base = dut_log.size();
        add_word(SYNC); add_word(32'h0001_0000);
        send_stream(0, 0);
        wait_end("t3_end");
        check("t3_error",    32'(error), 32'(1));
        check("t3_ready",    32'(byte_ready), 32'(0));
        check("t3_nstrobes", 32'(dut_log.size() - base), 32'(0));
        do_rearm();
        @(negedge CLK);
        check("t3_rearm_ready", 32'(byte_ready), 32'(1));
        check("t3_rearm_error", 32'(error), 32'(0));
        tick();

        // Three words with byte_valid jitter.
        base = dut_log.size();
        add_word(SYNC); add_word(32'd3);
        for (int i = 0; i < 3; i++) begin
            words[i] = $urandom;
            add_word(words[i]);
        end
        send_stream(1, 0);
        wait_end("t4_end");
        check("t4_done",     32'(done), 32'(1));
        check("t4_nstrobes", 32'(dut_log.size() - base), 32'(3));
        if (dut_log.size() >= base + 3)
            for (int i = 0; i < 3; i++) check("t4_word", dut_log[base + i], words[i]);
        do_rearm();

        // Reset after two payload bytes, then a fresh stream.
        base = dut_log.size();
        add_word(SYNC); add_word(32'd2);
        stream.push_back(8'hDE); stream.push_back(8'hAD);
        send_stream(0, 0);
        resetn = 0;
        #1;
        check("t5_rst_strobe", 32'(SelfWriteStrobe), 32'(0));
        check("t5_rst_data",   SelfWriteData, 32'h0);
        check("t5_rst_busy",   32'(busy), 32'(0));
        check("t5_rst_done",   32'(done), 32'(0));
        check("t5_rst_error",  32'(error), 32'(0));
        tick(); tick();
        resetn = 1;
        tick();
        check("t5_no_strobe", 32'(dut_log.size() - base), 32'(0));
        add_word(SYNC); add_word(32'd1); add_word(32'hA5A5_5A5A);
        send_stream(0, 0);
        wait_end("t5_end");
        check("t5_nstrobes", 32'(dut_log.size() - base), 32'(1));
        if (dut_log.size() > base) check("t5_word", dut_log[base], 32'hA5A5_5A5A);
        do_rearm();

        // Randomized streams with junk prefixes, rearm noise and bad counts.
        for (int it = 0; it < 14; it++) begin
            int r = $urandom_range(0, 9);
            int pre = $urandom_range(0, 6);
            for (int p = 0; p < pre; p++) stream.push_back(8'($urandom_range(0, 8'hEF)));
            add_word(SYNC);
            if (r == 0)      n = 32'd0;
            else if (r == 1) n = 32'h0001_0000 + $urandom_range(0, 1000);
            else if (r == 2) n = 32'hFFFF_0000;
            else             n = 32'($urandom_range(1, 4));
            add_word(n);
            if (n <= 4) for (int k = 0; k < int'(n); k++) add_word($urandom);
            send_stream(1, 1);
            wait_end("rand_end");
            do_rearm();
        end

        for (int t = 0; t < 200 && !gap0_finished; t++) tick();
        if (!gap0_finished) timeout_fail("gap0_finish");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // ---------------- zero-gap instance: strobe spacing ----------------
    initial begin
        logic [31:0] gw[4];
        int          sc[$];
        logic [31:0] sd[$];
        bit          acc0;
        logic [31:0] hdr0 = SYNC;
        for (int k = 0; k < 4; k++) s0[k] = hdr0[31 - 8*k -: 8];
        s0[4] = 8'h00; s0[5] = 8'h00; s0[6] = 8'h00; s0[7] = 8'h04;
        for (int k = 0; k < 4; k++) begin
            gw[k] = 32'h1020_3040 + 32'h0101_0101 * k;
            for (int b = 0; b < 4; b++) s0[8 + 4*k + b] = gw[k][31 - 8*b -: 8];
        end
        #1 rst0_n = 0;
        tick(); tick();
        rst0_n = 1;
        for (int c = 0; c < 80; c++) begin
            @(negedge CLK);
            acc0 = rdy0;
            if (stb0) begin sc.push_back(c); sd.push_back(dat0); end
            tick();
            if (acc0) idx0++;
        end
        check("g0_nstrobes", 32'(sc.size()), 32'(4));
        if (sc.size() == 4) begin
            for (int k = 0; k < 4; k++) check("g0_word", sd[k], gw[k]);
            for (int k = 1; k < 4; k++) check("g0_interval", 32'(sc[k] - sc[k-1]), 32'(5));
        end
        check("g0_done", 32'(done0), 32'(1));
        gap0_finished = 1;
    end

endmodule
